lcd_frame_fetcher: RTL
======================

Name: lcd_frame_fetcher

Overview:
- Upstream feeder for the 800x480 LCD timing generator.
- On the generator's once-per-frame data_request pulse, fetches one full frame from the memory framebuffer over an Avalon-MM burst read master into an on-chip show-ahead pixel FIFO.
- Presents the FIFO head as lcd_readdata, pops it on lcd_read, and reports no_data_available when the FIFO is empty.
- Single clock domain: clk is the LCD pixel clock.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BURST_LEN, 16, words per Avalon burst (power of 2, at most FIFO_DEPTH/2)
- FIFO_DEPTH, 512, pixel FIFO depth in words (power of 2)
- ADDR_W, 32, Avalon byte-address width

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- fb_base  in  ADDR_W  framebuffer byte base address; latched on accepted data_request
- data_request  in  1  one-cycle frame-prefetch pulse from the timing generator
- lcd_read  in  1  pop request from the timing generator
- lcd_readdata  out  24  FIFO head pixel {R,G,B}
- no_data_available  out  1  FIFO empty
- avm_address  out  ADDR_W  burst start byte address
- avm_read  out  1  read command
- avm_burstcount  out  5  burst length
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  pixel word; bits [23:0] used, [31:24] ignored
- avm_readdatavalid  in  1  read data beat
- underflow  out  1  sticky flag: lcd_read while FIFO empty
- overrun  out  1  sticky flag: data_request while a frame fetch is still busy
- clr_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset: all outputs 0, except no_data_available = 1. FIFO empty, outstanding = 0, FSM = IDLE.
- Frame size: TOTAL = H_ACTIVE*V_ACTIVE words (384000), 4 bytes per word, contiguous from fb_base.
- FSM states: IDLE, ARM, ISSUE, DRAIN.
  - IDLE: data_request = 1 and outstanding = 0 -> latch fb_base into addr_reg, load words_left = TOTAL, flush FIFO, go to ARM.
  - ARM: if free + 0 >= outstanding + BURST_LEN, go to ISSUE. free is FIFO_DEPTH minus fill level.
  - ISSUE: hold avm_read = 1 with stable address and burstcount until avm_waitrequest = 0. On that cycle:
    - addr_reg += 4*burst
    - words_left -= burst
    - outstanding += burst
    - next state: ARM if words_left remains nonzero, otherwise DRAIN.
  - DRAIN: go to IDLE when outstanding = 0.
- Burst size: burst = min(BURST_LEN, words_left), so a short final burst is allowed.
- outstanding counter:
  - increments by burst on command accept, decrements by 1 per avm_readdatavalid.
  - Simultaneous accept and beat in the same cycle net to burst-1.
  - Never negative.
- FIFO write: every avm_readdatavalid writes avm_readdata[23:0]. The space reservation in ARM guarantees the FIFO never overflows.
- FIFO read: show-ahead. lcd_readdata is valid whenever no_data_available = 0.
  - A pop occurs on lcd_read = 1 and FIFO not empty; the next word appears the following cycle.
  - Write and pop in the same cycle leave the fill level unchanged.
  - Write into an empty FIFO becomes visible (no_data_available falls) exactly 1 cycle after the readdatavalid cycle.
- lcd_read while empty: no pop, lcd_readdata holds its last value, underflow is set.
- data_request while FSM is not IDLE, or while outstanding != 0: ignored, overrun is set.
- Flags: clr_flags clears them; a set condition in the same cycle wins over the clear.
- Reset mid-frame clears everything. Any Avalon beats still arriving after reset are dropped, because outstanding = 0 and the FIFO is flushed. The system must reset the interconnect together with this block.
- Address arithmetic wraps modulo 2^ADDR_W. The words_left counter is 19 bits wide.

Decomposition:
- Shared package lcd_pkg:
  - H_ACTIVE, V_ACTIVE and timing constants shared with the timing generator
  - pixel_t (24-bit RGB)
  - the FSM state enum
- One sub-module: lcd_pixel_fifo, a synchronous show-ahead FIFO.
  - Parameters: DEPTH, WIDTH = 24.
  - Ports: wr_en/wr_data, rd_en/rd_data, empty, full, level.
  - Built on inferred dual-port RAM.

Test Plan:
- Reset, then a data_request pulse with fb_base = 0x1000_0000 and zero-latency slave -> first command address 0x1000_0000, burstcount 16. Second command address 0x1000_0040. Exactly 24000 bursts, then FSM returns to IDLE.
- Slave with waitrequest held for 5 cycles per command -> avm_read, avm_address and avm_burstcount stay stable throughout the stall. No duplicate bursts.
- lcd_read held low with a slow consumer -> fill level never exceeds 512. Fetch stalls in ARM and resumes after 16 pops free space.
- Memory returns an incrementing pattern; consumer pops 384000 words -> lcd_readdata sequence equals pattern[23:0] in order, with no gaps while no_data_available = 0.
- Second data_request issued while fetch is busy -> overrun = 1 and no restart. clr_flags then returns overrun to 0.
- lcd_read asserted on an empty FIFO right after reset -> underflow = 1 and no_data_available = 1. Reset asserted mid-frame -> all outputs return to reset values and FIFO is empty.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel geometry and timing, pixel type, fetch FSM states.
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_H_FRONT  = 40;
  localparam int LCD_H_SYNC   = 128;
  localparam int LCD_H_BACK   = 88;
  localparam int LCD_V_FRONT  = 1;
  localparam int LCD_V_SYNC   = 3;
  localparam int LCD_V_BACK   = 21;

  localparam int WORDS_LEFT_W = 19;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_ISSUE,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/lcd_pixel_fifo.sv
// Show-ahead pixel FIFO on an inferred dual-port RAM; the head is held when empty
// so the consumer sees the last presented pixel rather than stale RAM contents.
module lcd_pixel_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      hold <= rd_data;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
    end
  end

endmodule

// File: rtl/lcd_frame_fetcher.sv
// Per-frame framebuffer prefetch: Avalon-MM burst reads into the show-ahead pixel FIFO
// feeding the LCD timing generator.
module lcd_frame_fetcher
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE   = LCD_H_ACTIVE,
  parameter int V_ACTIVE   = LCD_V_ACTIVE,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              data_request,
  input  logic              lcd_read,
  output logic [23:0]       lcd_readdata,
  output logic              no_data_available,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [4:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              underflow,
  output logic              overrun,
  input  logic              clr_flags
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t             state, state_nxt;
  logic [ADDR_W-1:0]        addr_reg;
  logic [WORDS_LEFT_W-1:0]  words_left;
  logic [LW-1:0]            outstanding, level;
  logic [4:0]               burst;
  logic                     start, accept, beat, space_ok, fifo_empty, fifo_full;
  pixel_t                   head;
  logic                     unused_ok;

  assign burst    = (words_left >= WORDS_LEFT_W'(BURST_LEN)) ? 5'(BURST_LEN) : words_left[4:0];
  assign start    = data_request && (state == S_IDLE) && (outstanding == '0);
  assign accept   = (state == S_ISSUE) && !avm_waitrequest;
  // Beats with nothing outstanding belong to a fetch killed by reset: drop them.
  assign beat     = avm_readdatavalid && (outstanding != '0);
  // Reserve a full burst of FIFO space beyond everything already in flight.
  assign space_ok = (32'(FIFO_DEPTH) - 32'(level)) >= (32'(outstanding) + 32'(BURST_LEN));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARM;
      S_ARM:   if (space_ok) state_nxt = S_ISSUE;
      S_ISSUE: if (!avm_waitrequest)
                 state_nxt = (words_left == WORDS_LEFT_W'(burst)) ? S_DRAIN : S_ARM;
      S_DRAIN: if (outstanding == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      addr_reg    <= '0;
      words_left  <= '0;
      outstanding <= '0;
      underflow   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_reg   <= fb_base;
        words_left <= WORDS_LEFT_W'(TOTAL);
      end else if (accept) begin
        addr_reg   <= addr_reg + (ADDR_W'(burst) << 2);
        words_left <= words_left - WORDS_LEFT_W'(burst);
      end
      outstanding <= outstanding + (accept ? LW'(burst) : '0) - (beat ? LW'(1) : '0);
      underflow   <= (lcd_read && fifo_empty) || (underflow && !clr_flags);
      overrun     <= (data_request && !((state == S_IDLE) && (outstanding == '0)))
                     || (overrun && !clr_flags);
    end
  end

  lcd_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (start),
    .wr_en   (beat),
    .wr_data (avm_readdata[23:0]),
    .rd_en   (lcd_read),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  assign lcd_readdata      = head;
  assign no_data_available = fifo_empty;
  assign avm_read          = (state == S_ISSUE);
  assign avm_address       = addr_reg;
  assign avm_burstcount    = burst;
  assign unused_ok         = &{1'b0, avm_readdata[31:24], fifo_full};

endmodule
